// File: rtl/typing_scorer.sv
// Typing game scorer: tracks the typed buffer against the target word, runs the game FSM
// and derives accuracy/WPM with a sequential divider. Build macro: STRICT_COMMIT_EN.
module typing_scorer #(
  parameter int MAX_LEN  = 15,
  parameter int CHAR_W   = 5,
  parameter int CNT_W    = 11,
  parameter int TIME_MAX = 1800,
  parameter int STAT_W   = 10
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            tick,
  input  logic                            start,
  input  logic                            mode,
  input  logic [6:0]                      target,
  input  logic                            key_valid,
  input  logic [CHAR_W-1:0]               key_code,
  input  logic [MAX_LEN*CHAR_W-1:0]       word,
  input  logic [$clog2(MAX_LEN+1)-1:0]    word_len,
  output logic                            word_next,
  output logic [MAX_LEN*CHAR_W-1:0]       typed,
  output logic [$clog2(MAX_LEN+1)-1:0]    cursor,
  output logic [$clog2(MAX_LEN+1)-1:0]    correct,
  output logic [6:0]                      words_done,
  output logic [CNT_W-1:0]                timer,
  output logic [STAT_W-1:0]               acc,
  output logic [STAT_W-1:0]               wpm,
  output logic                            running,
  output logic                            finish
);

  localparam int LW = $clog2(MAX_LEN+1);
  localparam int DW = CNT_W + 8;
  localparam int CW = $clog2(DW);
  localparam logic [CNT_W-1:0]  TMAX      = CNT_W'(TIME_MAX);
  localparam logic [STAT_W-1:0] STAT_SAT  = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [2:0] {DV_IDLE, DV_ACC_LD, DV_ACC, DV_WPM_LD, DV_WPM} dv_t;

  state_t state, state_nxt;
  dv_t    dv_state;

  logic [MAX_LEN*CHAR_W-1:0] typed_q;
  logic [LW-1:0]             cursor_q, correct_q;
  logic [6:0]                words_q, target_q;
  logic                      mode_q;
  logic [CNT_W-1:0]          timer_q, remaining, typed_chars, good_chars;
  logic [CNT_W-1:0]          good_s, typed_s, timer_s, den;
  logic [CNT_W-1:0]          rem, step_rem;
  logic [DW-1:0]             quo, step_quo;
  logic [CNT_W:0]            trial;
  logic [CW-1:0]             cnt;
  logic                      req_pend;
  logic [STAT_W-1:0]         acc_q, wpm_q;
  logic [CHAR_W-1:0]         cur_char;

  logic run, game_start, done_cond, tick_do;
  logic is_letter, is_bksp, is_space;
  logic letter_do, bksp_do, commit_do, match, full_ok, stat_req;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  function automatic logic [STAT_W-1:0] sat_stat(input logic [DW-1:0] q);
    return (q > DW'(STAT_SAT)) ? STAT_SAT : q[STAT_W-1:0];
  endfunction

  always_comb begin
    cur_char = '0;
    for (int i = 0; i < MAX_LEN; i++)
      if (cursor_q == LW'(i)) cur_char = word[i*CHAR_W +: CHAR_W];
  end

  assign run        = (state == RUN);
  assign game_start = (state == IDLE) && start;
  assign done_cond  = (timer_q == TMAX) || (mode_q && (words_q == target_q)) ||
                      (!mode_q && (remaining == '0));
  assign tick_do    = run && tick;
  assign is_letter  = key_valid && (key_code >= CHAR_W'(1)) && (key_code <= CHAR_W'(26));
  assign is_bksp    = key_valid && (key_code == CHAR_W'(27));
  assign is_space   = key_valid && (key_code == CHAR_W'(28));
  assign match      = (cursor_q == correct_q) && (cursor_q < word_len) && (key_code == cur_char);
  assign full_ok    = (correct_q == cursor_q) && (cursor_q == word_len);
  assign letter_do  = run && is_letter && (cursor_q < LW'(MAX_LEN));
  assign bksp_do    = run && is_bksp && (cursor_q != '0);
`ifdef STRICT_COMMIT_EN
  assign commit_do  = run && is_space && (cursor_q != '0) && full_ok;
`else
  assign commit_do  = run && is_space && (cursor_q != '0);
`endif
  assign stat_req   = commit_do || tick_do;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (done_cond) state_nxt = DONE;
      DONE:    if (start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    running = (state == RUN);
    finish  = (state == DONE);
  end

  // Letters, backspace and space are mutually exclusive; ticks apply alongside any of them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      typed_q     <= '0;
      cursor_q    <= '0;
      correct_q   <= '0;
      words_q     <= '0;
      timer_q     <= '0;
      remaining   <= '0;
      typed_chars <= '0;
      good_chars  <= '0;
      mode_q      <= 1'b0;
      target_q    <= '0;
      word_next   <= 1'b0;
    end else if (game_start) begin
      typed_q     <= '0;
      cursor_q    <= '0;
      correct_q   <= '0;
      words_q     <= '0;
      timer_q     <= '0;
      remaining   <= mode ? '0 : CNT_W'(target) * CNT_W'(10);
      typed_chars <= '0;
      good_chars  <= '0;
      mode_q      <= mode;
      target_q    <= target;
      word_next   <= 1'b0;
    end else begin
      word_next <= commit_do;
      if (tick_do) begin
        if (timer_q != TMAX) timer_q <= timer_q + CNT_W'(1);
        if (!mode_q && remaining != '0) remaining <= remaining - CNT_W'(1);
      end
      if (letter_do) begin
        for (int i = 0; i < MAX_LEN; i++)
          if (cursor_q == LW'(i)) typed_q[i*CHAR_W +: CHAR_W] <= key_code;
        cursor_q    <= cursor_q + LW'(1);
        typed_chars <= sat_add(typed_chars, CNT_W'(1));
        if (match) correct_q <= correct_q + LW'(1);
      end
      if (bksp_do) begin
        for (int i = 0; i < MAX_LEN; i++)
          if (cursor_q == LW'(i+1)) typed_q[i*CHAR_W +: CHAR_W] <= '0;
        cursor_q <= cursor_q - LW'(1);
        if (correct_q == cursor_q) correct_q <= correct_q - LW'(1);
      end
      if (commit_do) begin
        good_chars  <= sat_add(good_chars, CNT_W'(correct_q) + CNT_W'(full_ok));
        typed_chars <= sat_add(typed_chars, CNT_W'(1));
        if (words_q != 7'h7f) words_q <= words_q + 7'd1;
        typed_q   <= '0;
        cursor_q  <= '0;
        correct_q <= '0;
      end
    end
  end

  // One restoring step: shift the next dividend bit into the partial remainder.
  always_comb begin
    trial = {rem, quo[DW-1]};
    if (trial >= {1'b0, den}) begin
      step_rem = trial[CNT_W-1:0] - den;
      step_quo = {quo[DW-2:0], 1'b1};
    end else begin
      step_rem = trial[CNT_W-1:0];
      step_quo = {quo[DW-2:0], 1'b0};
    end
  end

  // A job snapshots the counters, then divides for acc followed by wpm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_state <= DV_IDLE;
      req_pend <= 1'b0;
      good_s   <= '0;
      typed_s  <= '0;
      timer_s  <= '0;
      quo      <= '0;
      rem      <= '0;
      den      <= '0;
      cnt      <= '0;
      acc_q    <= '0;
      wpm_q    <= '0;
    end else if (game_start) begin
      dv_state <= DV_IDLE;
      req_pend <= 1'b0;
      acc_q    <= '0;
      wpm_q    <= '0;
    end else begin
      req_pend <= stat_req || (req_pend && (dv_state != DV_IDLE));
      case (dv_state)
        DV_IDLE: if (req_pend) begin
          good_s   <= good_chars;
          typed_s  <= typed_chars;
          timer_s  <= timer_q;
          dv_state <= DV_ACC_LD;
        end
        DV_ACC_LD: if (typed_s == '0) begin
          acc_q    <= '0;
          dv_state <= DV_WPM_LD;
        end else begin
          quo      <= DW'(good_s) * DW'(100);
          rem      <= '0;
          den      <= typed_s;
          cnt      <= '0;
          dv_state <= DV_ACC;
        end
        DV_ACC: begin
          quo <= step_quo;
          rem <= step_rem;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(DW-1)) begin
            acc_q    <= sat_stat(step_quo);
            dv_state <= DV_WPM_LD;
          end
        end
        DV_WPM_LD: if (timer_s == '0) begin
          wpm_q    <= '0;
          dv_state <= DV_IDLE;
        end else begin
          quo      <= DW'(good_s) * DW'(120);
          rem      <= '0;
          den      <= timer_s;
          cnt      <= '0;
          dv_state <= DV_WPM;
        end
        DV_WPM: begin
          quo <= step_quo;
          rem <= step_rem;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(DW-1)) begin
            wpm_q    <= sat_stat(step_quo);
            dv_state <= DV_IDLE;
          end
        end
        default: dv_state <= DV_IDLE;
      endcase
    end
  end

  assign typed      = typed_q;
  assign cursor     = cursor_q;
  assign correct    = correct_q;
  assign words_done = words_q;
  assign timer      = timer_q;
  assign acc        = acc_q;
  assign wpm        = wpm_q;

endmodule

// File: tb/tb_typing_scorer.sv
// Self-checking bench for typing_scorer: behavioural model plus a word_next scoreboard.
module tb_typing_scorer;

  logic        clk = 1'b0;
  logic        rst_n, tick, start, mode, key_valid;
  logic [6:0]  target;
  logic [4:0]  key_code;
  logic [74:0] word;
  logic [3:0]  word_len;
  logic        word_next, running, finish;
  logic [74:0] typed;
  logic [3:0]  cursor, correct;
  logic [6:0]  words_done;
  logic [10:0] timer;
  logic [9:0]  acc, wpm;

  int checks = 0;
  int failures = 0;
  int exp_q[$];

  // behavioural model state
  bit  m_run, m_mode;
  int  m_cur, m_cor, m_typed, m_good, m_words, m_timer, m_rem, m_len;
  int  m_buf[15];
  int  m_word[15];

  typing_scorer dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .mode(mode), .target(target),
    .key_valid(key_valid), .key_code(key_code), .word(word), .word_len(word_len),
    .word_next(word_next), .typed(typed), .cursor(cursor), .correct(correct),
    .words_done(words_done), .timer(timer), .acc(acc), .wpm(wpm),
    .running(running), .finish(finish)
  );

  always #5 clk = ~clk;

  // word_next scoreboard: each expected commit pushed its words_done value
  always @(negedge clk) begin
    if (rst_n === 1'b1 && word_next === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL word_next unexpected pulse, words_done=%0d", words_done);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (words_done !== 7'(e)) begin
          failures++;
          $display("[TB] FAIL word_next_words_done got=%0d exp=%0d", words_done, e);
        end
      end
    end
  end

  function automatic void model_clear();
    m_run = 0; m_cur = 0; m_cor = 0; m_typed = 0; m_good = 0; m_words = 0;
    m_timer = 0; m_rem = 0;
    for (int i = 0; i < 15; i++) m_buf[i] = 0;
  endfunction

  function automatic void model_tick();
    if (!m_run) return;
    if (m_timer != 1800) m_timer++;
    if (!m_mode && m_rem != 0) m_rem--;
  endfunction

  function automatic void model_key(input int code);
    bit full, ok;
    if (!m_run) return;
    if (code >= 1 && code <= 26) begin
      if (m_cur < 15) begin
        if (m_cur == m_cor && m_cur < m_len && code == m_word[m_cur]) m_cor++;
        m_buf[m_cur] = code;
        m_cur++;
        m_typed++;
      end
    end else if (code == 27) begin
      if (m_cur > 0) begin
        if (m_cor == m_cur) m_cor--;
        m_cur--;
        m_buf[m_cur] = 0;
      end
    end else if (code == 28 && m_cur > 0) begin
      full = (m_cor == m_cur) && (m_cur == m_len);
`ifdef STRICT_COMMIT_EN
      ok = full;
`else
      ok = 1'b1;
`endif
      if (ok) begin
        m_good += m_cor + int'(full);
        m_typed++;
        m_words++;
        exp_q.push_back(m_words);
        m_cur = 0; m_cor = 0;
        for (int i = 0; i < 15; i++) m_buf[i] = 0;
      end
    end
  endfunction

  function automatic logic [74:0] model_typed();
    logic [74:0] v;
    v = '0;
    for (int i = 0; i < 15; i++) v[i*5 +: 5] = 5'(m_buf[i]);
    return v;
  endfunction

  function automatic int exp_acc();
    int v;
    if (m_typed == 0) return 0;
    v = m_good * 100 / m_typed;
    return (v > 1023) ? 1023 : v;
  endfunction

  function automatic int exp_wpm();
    int v;
    if (m_timer == 0) return 0;
    v = m_good * 120 / m_timer;
    return (v > 1023) ? 1023 : v;
  endfunction

  task automatic press(input int code, input bit with_tick);
    @(negedge clk);
    key_valid = 1'b1; key_code = 5'(code); tick = with_tick;
    model_key(code);
    if (with_tick) model_tick();
    @(negedge clk);
    key_valid = 1'b0; tick = 1'b0;
  endtask

  task automatic type_cat();
    press(3, 0); press(1, 0); press(20, 0);
  endtask

  task automatic do_tick();
    @(negedge clk); tick = 1'b1; model_tick();
    @(negedge clk); tick = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic start_game(input bit md, input int tg);
    @(negedge clk); start = 1'b1; mode = md; target = 7'(tg);
    model_clear();
    m_run = 1; m_mode = md; m_rem = md ? 0 : tg * 10;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic settle();
    repeat (120) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b1; tick = 0; start = 0; mode = 0; target = 0; key_valid = 0; key_code = 0;
    word = '0; word[0 +: 5] = 5'd3; word[5 +: 5] = 5'd1; word[10 +: 5] = 5'd20; word_len = 4'd3;
    for (int i = 0; i < 15; i++) m_word[i] = 0;
    m_word[0] = 3; m_word[1] = 1; m_word[2] = 20; m_len = 3;
    model_clear();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({typed, cursor, correct} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_buffer typed=%h cursor=%0d correct=%0d exp=0", typed, cursor, correct);
    end
    checks++;
    if ({words_done, timer, acc, wpm} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_counters words=%0d timer=%0d acc=%0d wpm=%0d exp=0",
               words_done, timer, acc, wpm);
    end
    checks++;
    if ({running, finish, word_next} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_flags run=%b fin=%b wn=%b exp=000", running, finish, word_next);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word_commit();
    start_game(1, 2);
    type_cat();
    checks++;
    if (cursor !== 4'(m_cur) || correct !== 4'(m_cor)) begin
      failures++;
      $display("[TB] FAIL cat_prefix cursor=%0d correct=%0d exp=%0d/%0d", cursor, correct, m_cur, m_cor);
    end
    press(28, 0);
    checks++;
    if (cursor !== 4'(m_cur) || words_done !== 7'(m_words) || typed !== '0) begin
      failures++;
      $display("[TB] FAIL cat_commit cursor=%0d words=%0d exp=%0d/%0d", cursor, words_done, m_cur, m_words);
    end
    settle();
    checks++;
    if (acc !== 10'(exp_acc()) || wpm !== 10'(exp_wpm())) begin
      failures++;
      $display("[TB] FAIL cat_stats acc=%0d wpm=%0d exp=%0d/%0d", acc, wpm, exp_acc(), exp_wpm());
    end
  endtask

  task automatic test_backspace();
    press(3, 0); press(24, 0); press(27, 0); press(1, 0); press(20, 0);
    checks++;
    if (cursor !== 4'(m_cur) || correct !== 4'(m_cor) || typed !== model_typed()) begin
      failures++;
      $display("[TB] FAIL bksp_buffer cursor=%0d correct=%0d typed=%h exp=%0d/%0d/%h",
               cursor, correct, typed, m_cur, m_cor, model_typed());
    end
    press(28, 0);
    settle();
    m_run = 0;
    checks++;
    if (acc !== 10'(exp_acc()) || words_done !== 7'(m_words)) begin
      failures++;
      $display("[TB] FAIL bksp_stats acc=%0d words=%0d exp=%0d/%0d", acc, words_done, exp_acc(), m_words);
    end
    checks++;
    if (finish !== 1'b1 || running !== 1'b0) begin
      failures++;
      $display("[TB] FAIL word_target_done finish=%b running=%b exp=1/0", finish, running);
    end
    press(1, 0);
    checks++;
    if (cursor !== 4'd0) begin
      failures++;
      $display("[TB] FAIL key_in_done cursor=%0d exp=0", cursor);
    end
    pulse_start();
    checks++;
    if (finish !== 1'b0 || running !== 1'b0) begin
      failures++;
      $display("[TB] FAIL done_to_idle finish=%b running=%b exp=0/0", finish, running);
    end
  endtask

  task automatic test_timed();
    int waited;
    start_game(0, 1);
    repeat (9) do_tick();
    checks++;
    if (running !== 1'b1) begin
      failures++;
      $display("[TB] FAIL timed_still_running running=%b exp=1", running);
    end
    do_tick();
    waited = 0;
    while (finish !== 1'b1 && waited < 5) begin
      @(negedge clk);
      waited++;
    end
    m_run = 0;
    checks++;
    if (finish !== 1'b1) begin
      failures++;
      $display("[TB] FAIL timed_finish finish=%b exp=1 after %0d cycles", finish, waited);
    end
    settle();
    checks++;
    if (timer !== 11'(m_timer) || wpm !== 10'(exp_wpm()) || acc !== 10'(exp_acc())) begin
      failures++;
      $display("[TB] FAIL timed_stats timer=%0d wpm=%0d acc=%0d exp=%0d/%0d/%0d",
               timer, wpm, acc, m_timer, exp_wpm(), exp_acc());
    end
    pulse_start();
  endtask

  task automatic test_overflow();
    start_game(1, 5);
    repeat (16) press(1, 0);
    checks++;
    if (cursor !== 4'(m_cur) || correct !== 4'(m_cor) || typed !== model_typed()) begin
      failures++;
      $display("[TB] FAIL overflow_buffer cursor=%0d correct=%0d typed=%h exp=%0d/%0d/%h",
               cursor, correct, typed, m_cur, m_cor, model_typed());
    end
    repeat (16) press(27, 0);
    checks++;
    if (cursor !== 4'd0 || correct !== 4'd0 || typed !== '0) begin
      failures++;
      $display("[TB] FAIL bksp_at_zero cursor=%0d correct=%0d typed=%h exp=0", cursor, correct, typed);
    end
    type_cat();
    press(28, 0);
    settle();
    checks++;
    if (acc !== 10'(exp_acc()) || wpm !== 10'(exp_wpm())) begin
      failures++;
      $display("[TB] FAIL overflow_stats acc=%0d wpm=%0d exp=%0d/%0d", acc, wpm, exp_acc(), exp_wpm());
    end
  endtask

  task automatic test_back_to_back();
    type_cat();
    press(28, 1);
    checks++;
    if (timer !== 11'(m_timer)) begin
      failures++;
      $display("[TB] FAIL tick_with_commit timer=%0d exp=%0d", timer, m_timer);
    end
    do_tick();
    settle();
    checks++;
    if (timer !== 11'(m_timer) || acc !== 10'(exp_acc()) || wpm !== 10'(exp_wpm())) begin
      failures++;
      $display("[TB] FAIL pending_request timer=%0d acc=%0d wpm=%0d exp=%0d/%0d/%0d",
               timer, acc, wpm, m_timer, exp_acc(), exp_wpm());
    end
  endtask

  task automatic test_partial_commit();
    press(3, 0); press(1, 0); press(28, 0);
    settle();
    checks++;
    if (words_done !== 7'(m_words) || cursor !== 4'(m_cur)) begin
      failures++;
      $display("[TB] FAIL partial_commit words=%0d cursor=%0d exp=%0d/%0d", words_done, cursor, m_words, m_cur);
    end
    checks++;
    if (acc !== 10'(exp_acc()) || wpm !== 10'(exp_wpm())) begin
      failures++;
      $display("[TB] FAIL partial_stats acc=%0d wpm=%0d exp=%0d/%0d", acc, wpm, exp_acc(), exp_wpm());
    end
  endtask

  task automatic test_start_ignored();
    pulse_start();
    checks++;
    if (running !== 1'b1 || words_done !== 7'(m_words) || cursor !== 4'(m_cur)) begin
      failures++;
      $display("[TB] FAIL start_in_run running=%b words=%0d cursor=%0d exp=1/%0d/%0d",
               running, words_done, cursor, m_words, m_cur);
    end
  endtask

  task automatic test_reset_mid_div();
    press(27, 0); press(27, 0);
    type_cat();
    press(28, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    checks++;
    if ({acc, wpm, words_done, timer, cursor, running} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_mid_div acc=%0d wpm=%0d words=%0d timer=%0d exp=0",
               acc, wpm, words_done, timer);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_saturation();
    start_game(1, 5);
    type_cat(); press(28, 0);
    type_cat(); press(28, 0);
    type_cat(); press(28, 1);
    settle();
    checks++;
    if (acc !== 10'(exp_acc()) || wpm !== 10'(exp_wpm())) begin
      failures++;
      $display("[TB] FAIL wpm_saturation acc=%0d wpm=%0d exp=%0d/%0d", acc, wpm, exp_acc(), exp_wpm());
    end
  endtask

  initial begin
    test_reset();
    test_word_commit();
    test_backspace();
    test_timed();
    test_overflow();
    test_back_to_back();
    test_partial_commit();
    test_start_ignored();
    test_reset_mid_div();
    test_saturation();
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL word_next_missing pending=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
